// File: rtl/cva6_fifo_arb_pkg.sv
// Shared types for the CVA6 FIFO push arbiter: burst state encoding and counter width.
package cva6_fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned IDLE_CNT_WIDTH = 8;

endpackage

// File: rtl/cva6_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr, wrapping
// modulo NUM_REQ (works for non-power-of-two NUM_REQ).
module cva6_rr_pick #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 found
);

  always_comb begin
    int unsigned cand;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap instead of a power-of-two mask so odd NUM_REQ stays in range.
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && valid[IDX_WIDTH'(cand)]) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/cva6_fifo_push_arbiter.sv
// Round-robin push arbiter in front of a FIFO; a multi-word burst locks the grant to one
// requester until its last word, a flush, or an idle timeout.
module cva6_fifo_push_arbiter
  import cva6_fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned LOCK_TIMEOUT = 16,
  localparam int unsigned IDX_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                fifo_full_i,
  output logic                                fifo_push_o,
  output logic [IDX_WIDTH+DATA_WIDTH-1:0]     fifo_data_o,
  output logic                                fifo_flush_o,
  output logic [IDX_WIDTH-1:0]                grant_idx_o,
  output logic                                locked_o,
  output logic                                timeout_o
);

  arb_state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0]      lock_idx_q, lock_idx_d;
  logic [IDX_WIDTH-1:0]      last_grant_q;
  logic [IDLE_CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;

  logic [IDX_WIDTH-1:0] pick_idx;
  logic                 pick_found;
  logic [IDX_WIDTH-1:0] grant;
  logic                 grant_valid;
  logic                 push;
  logic                 timeout;

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
    return (i == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : i + IDX_WIDTH'(1);
  endfunction

  cva6_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_pick (
    .valid(req_valid_i),
    .ptr  (rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // With nothing eligible the index falls back to the previous grant so it holds steady.
  always_comb begin
    grant       = last_grant_q;
    grant_valid = 1'b0;
    if (state_q == LOCKED) begin
      grant       = lock_idx_q;
      grant_valid = req_valid_i[lock_idx_q];
    end else if (pick_found) begin
      grant       = pick_idx;
      grant_valid = 1'b1;
    end
  end

  assign push    = grant_valid & ~fifo_full_i & ~flush_i & ~rst_i;
  assign timeout = (state_q == LOCKED) & ~req_valid_i[lock_idx_q] & ~fifo_full_i & ~flush_i
                 & ~rst_i & (idle_cnt_q == IDLE_CNT_WIDTH'(LOCK_TIMEOUT - 1));

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = push;
  end

  assign fifo_push_o  = push;
  assign grant_idx_o  = rst_i ? '0 : grant;
  assign fifo_data_o  = {grant_idx_o, req_data_i[grant]};
  assign fifo_flush_o = flush_i & ~rst_i;
  assign locked_o     = (state_q == LOCKED) & ~rst_i;
  assign timeout_o    = timeout;

  // Flush beats everything (including a coinciding timeout); a full FIFO freezes all state.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    idle_cnt_d = idle_cnt_q;
    if (flush_i) begin
      state_d    = IDLE;
      idle_cnt_d = '0;
    end else if (!fifo_full_i) begin
      if (push) begin
        idle_cnt_d = '0;
        if (req_last_i[grant]) begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(grant);
        end else if (state_q == IDLE) begin
          state_d    = LOCKED;
          lock_idx_d = grant;
        end
      end else if (state_q == LOCKED) begin
        if (timeout) begin
          state_d    = IDLE;
          rr_ptr_d   = next_idx(lock_idx_q);
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      lock_idx_q   <= '0;
      idle_cnt_q   <= '0;
      last_grant_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_idx_q   <= lock_idx_d;
      idle_cnt_q   <= idle_cnt_d;
      last_grant_q <= grant;
    end
  end

endmodule

// File: tb/tb_cva6_fifo_push_arbiter.sv
// Directed bench for cva6_fifo_push_arbiter: a 4-requester instance (LOCK_TIMEOUT=4) and a
// 3-requester instance, checked against hand-computed grant sequences.
module tb_cva6_fifo_push_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic             flush;
  logic [3:0]       valid, last;
  logic [3:0][31:0] data;
  logic             full;
  logic [3:0]       ready;
  logic             push;
  logic [33:0]      fdata;
  logic             fflush;
  logic [1:0]       gidx;
  logic             locked, tmo;

  logic [2:0]       valid3, last3;
  logic [2:0][31:0] data3;
  logic [2:0]       ready3;
  logic             push3;
  logic [33:0]      fdata3;
  logic             fflush3;
  logic [1:0]       gidx3;
  logic             locked3, tmo3;

  int checks = 0;
  int errors = 0;

  cva6_fifo_push_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .LOCK_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(valid), .req_last_i(last), .req_data_i(data), .req_ready_o(ready),
    .fifo_full_i(full), .fifo_push_o(push), .fifo_data_o(fdata), .fifo_flush_o(fflush),
    .grant_idx_o(gidx), .locked_o(locked), .timeout_o(tmo)
  );

  cva6_fifo_push_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .LOCK_TIMEOUT(16)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .req_valid_i(valid3), .req_last_i(last3), .req_data_i(data3), .req_ready_o(ready3),
    .fifo_full_i(1'b0), .fifo_push_o(push3), .fifo_data_o(fdata3), .fifo_flush_o(fflush3),
    .grant_idx_o(gidx3), .locked_o(locked3), .timeout_o(tmo3)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f,
                               input logic fl);
    valid = v;
    last  = l;
    full  = f;
    flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectGrant(input string tag, input logic p, input logic [1:0] g);
    checkOutput({tag, ".push"}, 64'(push), 64'(p));
    checkOutput({tag, ".ready"}, 64'(ready), p ? 64'(4'b0001 << g) : 64'd0);
    if (p) begin
      checkOutput({tag, ".grant"}, 64'(gidx), 64'(g));
      checkOutput({tag, ".data"}, 64'(fdata), 64'({g, 32'hC0DE_0000 | 32'(g)}));
    end
  endtask

  task automatic expectGrant3(input string tag, input logic [1:0] g);
    checkOutput({tag, ".push"}, 64'(push3), 64'd1);
    checkOutput({tag, ".ready"}, 64'(ready3), 64'(3'b001 << g));
    checkOutput({tag, ".grant"}, 64'(gidx3), 64'(g));
    checkOutput({tag, ".data"}, 64'(fdata3), 64'({g, 32'hBEEF_0000 | 32'(g)}));
  endtask

  task automatic doReset(input string tag);
    rst    = 1'b1;
    valid  = 4'hF;
    last   = 4'hF;
    full   = 1'b0;
    flush  = 1'b1;
    valid3 = 3'b111;
    last3  = 3'b111;
    #1;
    checkOutput({tag, ".push"}, 64'(push), 64'd0);
    checkOutput({tag, ".ready"}, 64'(ready), 64'd0);
    checkOutput({tag, ".flush"}, 64'(fflush), 64'd0);
    checkOutput({tag, ".locked"}, 64'(locked), 64'd0);
    checkOutput({tag, ".timeout"}, 64'(tmo), 64'd0);
    checkOutput({tag, ".grant"}, 64'(gidx), 64'd0);
    checkOutput({tag, ".push3"}, 64'(push3), 64'd0);
    tick();
    rst    = 1'b0;
    flush  = 1'b0;
    valid  = 4'h0;
    last   = 4'h0;
    valid3 = 3'b000;
    last3  = 3'b000;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 32'hC0DE_0000 | 32'(i);
    for (int i = 0; i < 3; i++) data3[i] = 32'hBEEF_0000 | 32'(i);
    rst = 1'b1; flush = 1'b0; full = 1'b0; valid = '0; last = '0; valid3 = '0; last3 = '0;
    #2;

    // All four requesting single-word pushes: plain rotation 0,1,2,3,0.
    doReset("rst0");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 4'hF, 1'b0, 1'b0);
      expectGrant($sformatf("rr%0d", k), 1'b1, 2'(k % 4));
      tick();
    end

    // req1 three-word burst beats an always-valid req2; lock visible after word 1.
    doReset("rst1");
    applyStimulus(4'b0110, 4'b0100, 1'b0, 1'b0);
    expectGrant("burst.w1", 1'b1, 2'd1);
    checkOutput("burst.w1.locked", 64'(locked), 64'd0);
    tick();
    applyStimulus(4'b0110, 4'b0100, 1'b0, 1'b0);
    expectGrant("burst.w2", 1'b1, 2'd1);
    checkOutput("burst.w2.locked", 64'(locked), 64'd1);
    tick();
    applyStimulus(4'b0110, 4'b0110, 1'b0, 1'b0);
    expectGrant("burst.w3", 1'b1, 2'd1);
    checkOutput("burst.w3.locked", 64'(locked), 64'd1);
    tick();
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
    expectGrant("burst.req2", 1'b1, 2'd2);
    checkOutput("burst.req2.locked", 64'(locked), 64'd0);
    tick();

    // FIFO full stalls a locked req0 burst without losing the lock.
    doReset("rst2");
    applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
    expectGrant("full.w1", 1'b1, 2'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
      expectGrant($sformatf("full.stall%0d", k), 1'b0, 2'd0);
      checkOutput($sformatf("full.stall%0d.locked", k), 64'(locked), 64'd1);
      checkOutput($sformatf("full.stall%0d.grant", k), 64'(gidx), 64'd0);
      tick();
    end
    applyStimulus(4'b0011, 4'b0001, 1'b0, 1'b0);
    expectGrant("full.resume", 1'b1, 2'd0);
    tick();
    applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b0);
    expectGrant("full.next", 1'b1, 2'd1);
    tick();

    // req3 locks then goes quiet: timeout on the 4th idle cycle, then req0 wins.
    doReset("rst3");
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    expectGrant("tmo.lock", 1'b1, 2'd3);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
      expectGrant($sformatf("tmo.idle%0d", k), 1'b0, 2'd0);
      checkOutput($sformatf("tmo.idle%0d.pulse", k), 64'(tmo), (k == 3) ? 64'd1 : 64'd0);
      checkOutput($sformatf("tmo.idle%0d.locked", k), 64'(locked), 64'd1);
      tick();
    end
    applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
    expectGrant("tmo.after", 1'b1, 2'd0);
    checkOutput("tmo.after.pulse", 64'(tmo), 64'd0);
    checkOutput("tmo.after.locked", 64'(locked), 64'd0);
    tick();

    // Flush while locked on req2: no push, back to IDLE with rr_ptr still 0.
    doReset("rst4");
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
    expectGrant("flush.lock", 1'b1, 2'd2);
    tick();
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b1);
    expectGrant("flush.cyc", 1'b0, 2'd0);
    checkOutput("flush.cyc.fflush", 64'(fflush), 64'd1);
    tick();
    applyStimulus(4'b1100, 4'b1111, 1'b0, 1'b0);
    checkOutput("flush.after.locked", 64'(locked), 64'd0);
    checkOutput("flush.after.fflush", 64'(fflush), 64'd0);
    expectGrant("flush.after", 1'b1, 2'd2);
    tick();

    // Flush coinciding with a timeout suppresses the timeout pulse.
    doReset("rst5");
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    expectGrant("ftmo.lock", 1'b1, 2'd3);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    checkOutput("ftmo.pulse", 64'(tmo), 64'd0);
    checkOutput("ftmo.fflush", 64'(fflush), 64'd1);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("ftmo.after.locked", 64'(locked), 64'd0);
    checkOutput("ftmo.after.pulse", 64'(tmo), 64'd0);
    tick();

    // Reset in the middle of a req1 burst drops the lock.
    doReset("rst6");
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    expectGrant("rstb.lock", 1'b1, 2'd1);
    tick();
    doReset("rstb.mid");
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0);
    expectGrant("rstb.after", 1'b1, 2'd2);
    checkOutput("rstb.after.locked", 64'(locked), 64'd0);
    tick();

    // Three requesters: advance rr_ptr to 2, then only req0/req2 valid -> 2 then 0.
    doReset("rst7");
    valid3 = 3'b111; last3 = 3'b111; #1;
    expectGrant3("n3.g0", 2'd0);
    tick();
    valid3 = 3'b111; last3 = 3'b111; #1;
    expectGrant3("n3.g1", 2'd1);
    tick();
    valid3 = 3'b101; last3 = 3'b101; #1;
    expectGrant3("n3.g2", 2'd2);
    tick();
    valid3 = 3'b101; last3 = 3'b101; #1;
    expectGrant3("n3.wrap", 2'd0);
    tick();
    valid3 = 3'b000; #1;
    checkOutput("n3.hold.grant", 64'(gidx3), 64'd0);
    checkOutput("n3.hold.push", 64'(push3), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cva6_fifo_push_arbiter.md
CVA6_FIFO_PUSH_ARBITER -- requirements
Module: cva6_fifo_push_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width per requester.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 16, idle cycles before a burst lock is revoked (1..255).
REQ-004 SHALL have derived parameter IDX_WIDTH, default (NUM_REQ>1 ? clog2(NUM_REQ) : 1), requester index width; it is not overridden.
REQ-005 SHALL have port clk_i  in  1  the single clock.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port flush_i  in  1  abort bursts and flush the downstream FIFO.
REQ-008 SHALL have port req_valid_i  in  NUM_REQ  per-requester push request.
REQ-009 SHALL have port req_last_i  in  NUM_REQ  word is the last of a burst.
REQ-010 SHALL have port req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester payload.
REQ-011 SHALL have port req_ready_o  out  NUM_REQ  word accepted this cycle (one-hot or zero).
REQ-012 SHALL have port fifo_full_i  in  1  full flag of the downstream FIFO.
REQ-013 SHALL have port fifo_push_o  out  1  push strobe to the FIFO.
REQ-014 SHALL have port fifo_data_o  out  IDX_WIDTH+DATA_WIDTH  {granted index, payload}.
REQ-015 SHALL have port fifo_flush_o  out  1  flush strobe to the FIFO.
REQ-016 SHALL have port grant_idx_o  out  IDX_WIDTH  current granted index.
REQ-017 SHALL have port locked_o  out  1  state is LOCKED.
REQ-018 SHALL have port timeout_o  out  1  one-cycle pulse on lock revocation.

Function
REQ-019 SHALL implement the states IDLE and LOCKED, plus registers rr_ptr (IDX_WIDTH), lock_idx (IDX_WIDTH) and idle_cnt (8 bits).
REQ-020 In IDLE, the grant SHALL go combinationally to the first asserted req_valid_i at or after rr_ptr, wrapping modulo NUM_REQ; this SHALL work for NUM_REQ values that are not a power of two.
REQ-021 In LOCKED, only lock_idx SHALL be eligible, and all other req_ready_o SHALL be 0.
REQ-022 fifo_push_o SHALL equal (granted valid & ~fifo_full_i & ~flush_i), and req_ready_o[grant] SHALL equal fifo_push_o, with zero added latency.
REQ-023 fifo_data_o SHALL equal {grant_idx_o, req_data_i[grant]}, and grant_idx_o SHALL hold its last value when no requester is valid.
REQ-024 A push in IDLE with last=0 SHALL move the state to LOCKED and set lock_idx to the grant.
REQ-025 A push with last=1, in either state, SHALL move the state to IDLE and set rr_ptr to (grant+1) mod NUM_REQ.
REQ-026 rr_ptr SHALL change only on a burst-ending push, a timeout or reset.
REQ-027 While fifo_full_i=1, there SHALL be no push and no state or rr_ptr change, and idle_cnt SHALL hold.
REQ-028 In LOCKED, idle_cnt SHALL increment each cycle req_valid_i[lock_idx]=0 and SHALL clear on any valid from lock_idx.
REQ-029 When idle_cnt reaches LOCK_TIMEOUT-1 and the requester is still invalid, the block SHALL go to IDLE, set rr_ptr to lock_idx+1 mod NUM_REQ, clear idle_cnt and pulse timeout_o for one cycle.
REQ-030 flush_i SHALL drive fifo_flush_o combinationally and suppress the push that cycle.
REQ-031 flush_i SHALL set the next state to IDLE and clear idle_cnt, while rr_ptr is kept.
REQ-032 If flush_i and a timeout occur in the same cycle, flush SHALL take precedence and timeout_o SHALL stay 0.

Reset
REQ-033 On rst_i=1 (asynchronous), the block SHALL clear state to IDLE and set rr_ptr, lock_idx and idle_cnt to 0.
REQ-034 During reset, fifo_push_o, req_ready_o, fifo_flush_o, locked_o and timeout_o SHALL be 0, and grant_idx_o SHALL be 0.
REQ-035 A reset asserted mid-burst SHALL discard the lock with no push emitted.

Structure
REQ-036 The state enum (IDLE, LOCKED) SHALL live in the shared package cva6_fifo_arb_pkg.
REQ-037 The round-robin picker SHALL be the combinational sub-module cva6_rr_pick (valid vector, pointer -> index, found flag).
REQ-038 The block SHALL contain no storage for payload.

Verification
REQ-039 Bench SHALL cover: all 4 valid, last=1, FIFO never full -> grants 0,1,2,3,0 on consecutive cycles, one push per cycle.
REQ-040 Bench SHALL cover: req1 burst of 3 (last on word 3) with req2 always valid -> pushes 1,1,1,2, with locked_o=1 for the 2 cycles after word 1.
REQ-041 Bench SHALL cover: fifo_full_i=1 for 5 cycles during a req0 burst -> no push and ready=0; state and rr_ptr unchanged; the burst resumes after.
REQ-042 Bench SHALL cover: LOCK_TIMEOUT=4, req3 locks then drops valid -> timeout_o pulses after 4 idle cycles and the next grant goes to req0.
REQ-043 Bench SHALL cover: flush_i asserted while LOCKED with req2 valid -> fifo_flush_o=1, no push, IDLE next cycle, rr_ptr unchanged.
REQ-044 Bench SHALL cover: NUM_REQ=3, rr_ptr=2, only req0 and req2 valid -> grant 2 then 0.
